// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate test sequencer: FSM state encoding and
// reference truth tables for common 2-input gates (bit i = y for {a,b}=i).
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Loadable down-counter that measures how long each vector is held on the
// gate before its output is sampled. expired is high while the count is zero.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       en,
  output logic       expired
);

  logic [3:0] count;

  // Load on request, otherwise count down while enabled and stop at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expired = (count == 4'd0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Drives all four input combinations to a 2-input gate, waits for the gate to
// settle, samples its output against a latched truth table and reports the
// mismatch count, first failing vector and an overall pass flag.
module gate_test_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] truth_table,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] first_fail,
  output logic       fail_valid
);

  import gate_seq_pkg::*;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_LOOP   = 8'(LOOPS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] vector;
  logic [7:0] loop_cnt;
  logic [3:0] tt_latched;
  logic       accept;
  logic       sample_en;
  logic       last_sample;
  logic       mismatch;
  logic [3:0] err_nxt;
  logic       timer_load;
  logic       timer_expired;

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (SETTLE_LOAD),
    .en         (state == SETTLE),
    .expired    (timer_expired)
  );

  // Next-state decode, timer reload and the gate/status outputs
  always_comb begin
    state_nxt   = state;
    timer_load  = 1'b0;
    gate_a      = 1'b0;
    gate_b      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    accept      = 1'b0;
    sample_en   = 1'b0;
    last_sample = (vector == 2'd3) && (loop_cnt == LAST_LOOP);
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        busy   = 1'b1;
        gate_a = vector[1];
        gate_b = vector[0];
        if (abort) begin
          state_nxt = IDLE;
        end else if (timer_expired) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        busy   = 1'b1;
        gate_a = vector[1];
        gate_b = vector[0];
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          sample_en = 1'b1;
          if (last_sample) begin
            state_nxt = DONE;
          end else begin
            timer_load = 1'b1;
            state_nxt  = SETTLE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    mismatch = sample_en && (gate_y != tt_latched[vector]);
    err_nxt  = (mismatch && (err_count != 4'hF)) ? err_count + 4'd1 : err_count;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Run bookkeeping: vector/loop position, latched table and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vector     <= 2'd0;
      loop_cnt   <= 8'd0;
      tt_latched <= 4'd0;
      err_count  <= 4'd0;
      first_fail <= 2'd0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else if (accept) begin
      vector     <= 2'd0;
      loop_cnt   <= 8'd0;
      tt_latched <= truth_table;
      err_count  <= 4'd0;
      first_fail <= 2'd0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
    end else if (sample_en) begin
      err_count <= err_nxt;
      if (mismatch && !fail_valid) begin
        first_fail <= vector;
        fail_valid <= 1'b1;
      end
      vector <= vector + 2'd1;
      if (vector == 2'd3) begin
        loop_cnt <= loop_cnt + 8'd1;
      end
      // pass reflects the final count including this last sample
      if (last_sample) begin
        pass <= (err_nxt == 4'd0);
      end
    end else if (busy && abort) begin
      vector   <= 2'd0;
      loop_cnt <= 8'd0;
    end
  end

endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles each input vector is held before sampling; legal range 1..15.
REQ-002 SHALL have parameter LOOPS, default 1, full truth-table sweeps per run; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate run, sampled every cycle.
REQ-007 SHALL have port truth_table  input  4  expected output; bit i = expected gate_y for vector i = {gate_a,gate_b}.
REQ-008 SHALL have port gate_a  output  1  first operand driven to the 2-input gate under control.
REQ-009 SHALL have port gate_b  output  1  second operand driven to the gate.
REQ-010 SHALL have port gate_y  input  1  gate output returned for checking.
REQ-011 SHALL have port busy  output  1  high while a run is active.
REQ-012 SHALL have port done  output  1  one-cycle pulse at normal run completion.
REQ-013 SHALL have port pass  output  1  high when the completed run had zero mismatches.
REQ-014 SHALL have port err_count  output  4  mismatch count, saturating at 15.
REQ-015 SHALL have port first_fail  output  2  vector index of the first mismatch.
REQ-016 SHALL have port fail_valid  output  1  high once first_fail holds a captured value.

Function
REQ-017 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-018 IDLE: start=1 and abort=0 SHALL latch truth_table, clear err_count/first_fail/fail_valid/pass, set vector=0, loop=0, and go to SETTLE next cycle with busy=1.
REQ-019 SHALL drive gate_a=vector[1], gate_b=vector[0] in SETTLE and SAMPLE; both 0 in IDLE and DONE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-021 SAMPLE SHALL last one cycle and compare gate_y with latched truth_table[vector].
REQ-022 On a mismatch, err_count SHALL increment, holding at 15 once reached. On the first mismatch of the run, first_fail SHALL be set to vector and fail_valid to 1.
REQ-023 After SAMPLE: if vector<3, vector SHALL increment and return to SETTLE.
REQ-024 After SAMPLE with vector=3: vector SHALL wrap to 0 and loop SHALL increment. If loop=LOOPS-1, go to DONE; otherwise return to SETTLE.
REQ-025 DONE SHALL last one cycle with done=1, busy=0, pass=(err_count==0); it then returns to IDLE.
REQ-026 Latency: start sampled at edge 0 SHALL produce done in cycle 1+LOOPS*4*(SETTLE_CYCLES+1).
REQ-027 abort=1 in SETTLE/SAMPLE SHALL return to IDLE next cycle with busy=0, no done, pass=0, and err_count/first_fail frozen.
REQ-028 start while busy or in DONE SHALL be ignored. start and abort together in IDLE SHALL keep IDLE; abort wins.
REQ-029 Results SHALL hold until the next accepted start.
REQ-030 truth_table changes mid-run SHALL have no effect on the active run.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, vector=0, loop=0, and all outputs 0, including mid-run.
REQ-032 The first start SHALL be accepted at the first edge after rst_n returns high.

Structure
REQ-033 Shared package gate_seq_pkg SHALL hold the state encodings and truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111.
REQ-034 SHALL instantiate one sub-module, settle_timer: a loadable down-counter with a load input and an expired output.
REQ-035 SHALL contain no latches and no combinational path from gate_y to any output.

Verification
REQ-036 Good AND gate, truth_table=TT_AND, SETTLE_CYCLES=2, LOOPS=1, start at cycle 0 -> done in cycle 13, pass=1, err_count=0, fail_valid=0.
REQ-037 AND gate, truth_table=TT_OR -> mismatches at vectors 1 and 2; err_count=2, first_fail=1, pass=0.
REQ-038 gate_y stuck at 1, truth_table=TT_AND, LOOPS=8 -> 24 mismatches; err_count saturates at 15, first_fail=0.
REQ-039 abort at cycle 5 of a run -> cycle 6 busy=0, gate_a=gate_b=0, no done pulse, pass=0.
REQ-040 start pulsed at cycle 4 of a run, and start+abort together in IDLE -> no restart and no state change.
REQ-041 rst_n low at cycle 7 of a run -> all outputs 0 after that edge; a fresh start then completes normally.
